// File: rtl/usb_serial_arb_pkg.sv
// usb_serial_arb_pkg
//   Shared definitions for the USB serial TX arbiter and later arbiters that
//   reuse the same stream framing.
//   - state_t            : arbiter state encoding (IDLE=0, HDR=1, BURST=2)
//   - USB_SERIAL_HDR_TAG : upper nibble of the per-burst stream header byte
//   - DEF_MAX_BURST      : default bytes per grant
//   - DEF_HOLD_CYCLES    : default idle cycles tolerated before release
//   - wrap_inc()         : index increment wrapping at n-1 back to 0
package usb_serial_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  localparam logic [3:0] USB_SERIAL_HDR_TAG = 4'hF;
  localparam int DEF_MAX_BURST   = 32;
  localparam int DEF_HOLD_CYCLES = 8;

  function automatic logic [3:0] wrap_inc(input logic [3:0] idx, input int n);
    logic [3:0] r;
    if (int'(idx) >= n - 1) r = 4'd0;
    else                    r = idx + 4'd1;
    return r;
  endfunction

endpackage

// File: rtl/usb_serial_arb_rr_pick.sv
// rr_pick
//   Combinational round-robin selector: returns the first asserted request at
//   or after the pointer, wrapping modulo NUM_SRC.
//   Ports:
//     i_req   [NUM_SRC-1:0]  request vector
//     i_ptr   [3:0]          search start index (< NUM_SRC)
//     o_found                at least one request asserted
//     o_idx   [3:0]          selected index (0 when nothing found)
module rr_pick #(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [3:0]         i_ptr,
  output logic               o_found,
  output logic [3:0]         o_idx
);

  function automatic int wrap_add(input int p, input int k);
    int s;
    s = p + k;
    return (s >= NUM_SRC) ? s - NUM_SRC : s;
  endfunction

  // Scan from the farthest offset down to offset 0 so the closest request to
  // the pointer is the last (and therefore winning) assignment.
  always_comb begin
    o_found = 1'b0;
    o_idx   = 4'd0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (i_req[wrap_add(int'(i_ptr), k)]) begin
        o_found = 1'b1;
        o_idx   = 4'(wrap_add(int'(i_ptr), k));
      end
    end
  end

endmodule

// File: rtl/usb_serial_arb.sv
// usb_serial_arb
//   Round-robin arbiter sharing the single byte stream into the USB serial IN
//   endpoint among NUM_SRC producers. A grant covers one burst; it ends on a
//   message end (src_last), after MAX_BURST bytes, or after HOLD_CYCLES idle
//   cycles. A stall (uart_tx_ready low) never ends a grant.
//   Build option: define USB_SERIAL_ARB_HDR_EN to prefix every burst with the
//   header byte 8'hF0|cur_src so the host can demux streams.
//   Ports:
//     clk, reset      clock, synchronous active-high reset
//     src_valid/data/last  per-source byte lanes (lane i = src_data[8i+7:8i])
//     src_ack         combinational consume indication per source
//     uart_tx_ready   downstream FIFO can take a byte
//     uart_tx_data    registered byte, valid with uart_tx_strobe
//     uart_tx_strobe  registered one-cycle write strobe
//     busy, cur_src   registered grant status and granted index
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | no grant; picks next requester from rr pointer
//   ST_HDR   | granted; emitting the stream header byte (HDR build only)
//   ST_BURST | granted; forwarding bytes from cur_src
module usb_serial_arb
  import usb_serial_arb_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int MAX_BURST   = DEF_MAX_BURST,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SRC-1:0]     src_valid,
  input  logic [8*NUM_SRC-1:0]   src_data,
  input  logic [NUM_SRC-1:0]     src_last,
  output logic [NUM_SRC-1:0]     src_ack,
  input  logic                   uart_tx_ready,
  output logic [7:0]             uart_tx_data,
  output logic                   uart_tx_strobe,
  output logic                   busy,
  output logic [3:0]             cur_src
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  state_t     r_state;
  logic [3:0] r_cur;
  logic [3:0] r_rr;
  logic [7:0] r_byte_cnt;
  logic [7:0] r_idle_cnt;
  logic [7:0] r_tx_data;
  logic       r_tx_strobe;
  logic       r_busy;

  logic          w_found;
  logic [3:0]    w_pick;
  logic [IW-1:0] w_cur_idx;
  logic [7:0]    w_lane [NUM_SRC];
  logic          w_cur_valid;
  logic          w_consume;
  logic [7:0]    w_byte_next;
  logic [7:0]    w_idle_next;
  logic          w_rel_consume;
  logic          w_rel_idle;

  rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .i_req   (src_valid),
    .i_ptr   (r_rr),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) w_lane[i] = src_data[8*i +: 8];
  end

  assign w_cur_idx   = r_cur[IW-1:0];
  assign w_cur_valid = src_valid[w_cur_idx];
  // Gated by reset so an ack can never be issued for a byte the reset drops.
  assign w_consume   = (r_state == ST_BURST) && w_cur_valid && uart_tx_ready && !reset;
  assign w_byte_next = r_byte_cnt + 8'd1;
  assign w_idle_next = r_idle_cnt + 8'd1;

  // last and burst limit on the same byte collapse into one release.
  assign w_rel_consume = src_last[w_cur_idx] || (w_byte_next == 8'(MAX_BURST));
  // A stall (ready low) is not idleness; only ready-high/valid-low counts.
  assign w_rel_idle    = (w_idle_next == 8'(HOLD_CYCLES));

  always_comb begin
    src_ack = '0;
    if (w_consume) src_ack[w_cur_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cur       <= 4'd0;
      r_rr        <= 4'd0;
      r_byte_cnt  <= 8'd0;
      r_idle_cnt  <= 8'd0;
      r_tx_data   <= 8'd0;
      r_tx_strobe <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_tx_strobe <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_cur      <= w_pick;
            r_busy     <= 1'b1;
            r_byte_cnt <= 8'd0;
            r_idle_cnt <= 8'd0;
`ifdef USB_SERIAL_ARB_HDR_EN
            r_state    <= ST_HDR;
`else
            r_state    <= ST_BURST;
`endif
          end
        end
`ifdef USB_SERIAL_ARB_HDR_EN
        ST_HDR: begin
          if (uart_tx_ready) begin
            r_tx_data   <= {USB_SERIAL_HDR_TAG, r_cur};
            r_tx_strobe <= 1'b1;
            r_state     <= ST_BURST;
          end
        end
`endif
        ST_BURST: begin
          if (w_consume) begin
            r_tx_data   <= w_lane[w_cur_idx];
            r_tx_strobe <= 1'b1;
            r_byte_cnt  <= w_byte_next;
            r_idle_cnt  <= 8'd0;
            if (w_rel_consume) begin
              r_busy  <= 1'b0;
              r_rr    <= wrap_inc(r_cur, NUM_SRC);
              r_state <= ST_IDLE;
            end
          end else if (uart_tx_ready && !w_cur_valid) begin
            r_idle_cnt <= w_idle_next;
            if (w_rel_idle) begin
              r_busy  <= 1'b0;
              r_rr    <= wrap_inc(r_cur, NUM_SRC);
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign uart_tx_data   = r_tx_data;
  assign uart_tx_strobe = r_tx_strobe;
  assign busy           = r_busy;
  assign cur_src        = r_cur;

endmodule
